// File: rtl/conv_pkg.sv
// Shared definitions for the convolution read-side sequencer.
//   - Bank enable encodings driven towards memory_module.
//   - Matrix dimensions: 4x4 input, 3x3 filter, 2x2 valid output.
//   - Sequencer state encoding.
package conv_pkg;

    localparam logic [1:0] EN_IDLE  = 2'b00;
    localparam logic [1:0] EN_READ  = 2'b10;
    localparam logic [1:0] EN_WRITE = 2'b11;

    localparam int unsigned IN_DIM  = 4;
    localparam int unsigned FIL_DIM = 3;
    localparam int unsigned OUT_DIM = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WRITE,
        DONE
    } state_e;

endpackage

// File: rtl/conv_window_reader_if.sv
// Bus between conv_window_reader, memory_module and the top-level controller.
//   start                    controller -> reader, run request
//   addr_A0..2 / addr_F0..2  reader -> memory, read addresses (row-major)
//   en_INP / en_FIL          reader -> memory, bank enables
//   out_A0..2 / out_F0..2    memory -> reader, read data (one cycle after address)
//   data_w / addr_S0 / en_S  reader -> memory, serial-mode result write
//   busy / done              reader -> controller, status
//   result_full              reader -> observer, unsaturated last result
// Modport master is the reader side, slave the memory/controller side.
interface conv_window_reader_if #(
    parameter int unsigned ACC_W = 20
);

    logic             start;
    logic [3:0]       addr_A0, addr_A1, addr_A2;
    logic [3:0]       addr_F0, addr_F1, addr_F2;
    logic [1:0]       en_INP, en_FIL;
    logic [7:0]       out_A0, out_A1, out_A2;
    logic [7:0]       out_F0, out_F1, out_F2;
    logic [7:0]       data_w;
    logic [1:0]       addr_S0;
    logic [1:0]       en_S;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] result_full;

    modport master (
        input  start,
        input  out_A0, out_A1, out_A2, out_F0, out_F1, out_F2,
        output addr_A0, addr_A1, addr_A2, addr_F0, addr_F1, addr_F2,
        output en_INP, en_FIL, data_w, addr_S0, en_S, busy, done, result_full
    );

    modport slave (
        output start,
        output out_A0, out_A1, out_A2, out_F0, out_F1, out_F2,
        input  addr_A0, addr_A1, addr_A2, addr_F0, addr_F1, addr_F2,
        input  en_INP, en_FIL, data_w, addr_S0, en_S, busy, done, result_full
    );

endinterface

// File: rtl/conv_mac3.sv
// One filter row of the convolution: three unsigned 8x8 products summed.
//   a0..a2  in  8   input-matrix samples
//   f0..f2  in  8   filter coefficients
//   sum     out 18  a0*f0 + a1*f1 + a2*f2
// Purely combinational.
module conv_mac3 (
    input  logic [7:0]  a0,
    input  logic [7:0]  a1,
    input  logic [7:0]  a2,
    input  logic [7:0]  f0,
    input  logic [7:0]  f1,
    input  logic [7:0]  f2,
    output logic [17:0] sum
);

    logic [15:0] p0, p1, p2;

    assign p0  = 16'(a0) * 16'(f0);
    assign p1  = 16'(a1) * 16'(f1);
    assign p2  = 16'(a2) * 16'(f2);
    assign sum = 18'(p0) + 18'(p1) + 18'(p2);

endmodule

// File: rtl/conv_window_reader.sv
// Read-side sequencer: runs a 3x3 valid convolution over the 4x4 input held in
// memory_module and writes the 2x2 saturated results to the serial output memory.
//   clk, rst  rising-edge clock, synchronous active-high reset
//   bus       conv_window_reader_if master: start/busy/done, read ports,
//             result write port and result_full
// Each output takes 5 cycles: RUN ph0..ph3 (rows issued in ph0..ph2, data
// accumulated one cycle later in ph1..ph3) followed by one WRITE cycle.
module conv_window_reader
    import conv_pkg::*;
#(
    parameter int unsigned OUT_SHIFT = 0,
    parameter int unsigned ACC_W     = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_window_reader_if.master bus
);

    state_e           state_q, state_d;
    logic [1:0]       ph_q, ph_d;
    logic [1:0]       idx_q, idx_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] last_q, last_d;
    logic             armed_q, armed_d;

    logic [17:0]      row_sum;
    logic [1:0]       arow;
    logic [3:0]       a_base, f_base;
    logic [ACC_W-1:0] acc_shr;

    conv_mac3 u_mac (
        .a0  (bus.out_A0),
        .a1  (bus.out_A1),
        .a2  (bus.out_A2),
        .f0  (bus.out_F0),
        .f1  (bus.out_F1),
        .f2  (bus.out_F2),
        .sum (row_sum)
    );

    // Window origin is (idx[1], idx[0]); ph doubles as the filter row while issuing.
    always_comb begin
        arow   = {1'b0, idx_q[1]} + ph_q;
        a_base = 4'(arow * IN_DIM) + 4'(idx_q[0]);
        f_base = 4'(ph_q * FIL_DIM);
    end

    assign acc_shr = acc_q >> OUT_SHIFT;

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        last_d  = last_q;
        // A held start launches only one run: it must drop before another is taken.
        armed_d = armed_q | ~bus.start;
        unique case (state_q)
            IDLE: begin
                if (bus.start && armed_q) begin
                    state_d = RUN;
                    ph_d    = 2'd0;
                    idx_d   = 2'd0;
                    armed_d = 1'b0;
                end
            end
            RUN: begin
                ph_d = ph_q + 2'd1;
                if (ph_q == 2'd1) begin
                    acc_d = ACC_W'(row_sum);
                end else if (ph_q != 2'd0) begin
                    acc_d = acc_q + ACC_W'(row_sum);
                end
                if (ph_q == 2'(FIL_DIM)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                last_d = acc_q;
                ph_d   = 2'd0;
                if (idx_q == 2'(OUT_DIM * OUT_DIM - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.addr_A0     = '0;
        bus.addr_A1     = '0;
        bus.addr_A2     = '0;
        bus.addr_F0     = '0;
        bus.addr_F1     = '0;
        bus.addr_F2     = '0;
        bus.en_INP      = EN_IDLE;
        bus.en_FIL      = EN_IDLE;
        bus.data_w      = '0;
        bus.addr_S0     = '0;
        bus.en_S        = EN_IDLE;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        bus.result_full = last_q;
        unique case (state_q)
            IDLE: begin
            end
            RUN: begin
                bus.busy = 1'b1;
                if (ph_q != 2'(FIL_DIM)) begin
                    bus.en_INP  = EN_READ;
                    bus.en_FIL  = EN_READ;
                    bus.addr_A0 = a_base;
                    bus.addr_A1 = a_base + 4'd1;
                    bus.addr_A2 = a_base + 4'd2;
                    bus.addr_F0 = f_base;
                    bus.addr_F1 = f_base + 4'd1;
                    bus.addr_F2 = f_base + 4'd2;
                end
            end
            WRITE: begin
                bus.busy        = 1'b1;
                bus.en_S        = EN_WRITE;
                bus.addr_S0     = idx_q;
                bus.data_w      = (acc_shr > ACC_W'(255)) ? 8'hff : acc_shr[7:0];
                bus.result_full = acc_q;
            end
            DONE: begin
                bus.done = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ph_q    <= 2'd0;
            idx_q   <= 2'd0;
            acc_q   <= '0;
            last_q  <= '0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            last_q  <= last_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: tb/tb_conv_window_reader.sv
// Scoreboard bench: three readers (OUT_SHIFT 0, 1, 2) share one memory image and
// run in lockstep. Stimulus pushes expected reads, writes and done cycles; a
// single negedge monitor pops and compares whenever the DUTs present them.
module tb_conv_window_reader;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem_a [16];
    logic [7:0] mem_f [16];

    typedef struct packed {
        logic [2:0][3:0] a;
        logic [2:0][3:0] f;
    } rd_t;

    typedef struct packed {
        logic [1:0]      addr;
        logic [19:0]     full;
        logic [2:0][7:0] d;
    } wr_t;

    rd_t rd_q [$];
    wr_t wr_q [$];
    int  done_q [$];

    int compared   = 0;
    int mismatched = 0;
    int mode       = 0;
    bit mon_on     = 1'b0;
    bit final_chk  = 1'b0;
    bit final_seen = 1'b0;

    int exp_full [4] = '{303, 348, 483, 528};
    int exp_d1   [4] = '{151, 174, 241, 255};
    int exp_d2   [4] = '{75, 87, 120, 132};

    logic [2:0][3:0] mon_a [3];
    logic [2:0][3:0] mon_f [3];
    logic [1:0]      mon_en_inp [3];
    logic [1:0]      mon_en_fil [3];
    logic [1:0]      mon_en_s [3];
    logic [1:0]      mon_addr_s [3];
    logic [7:0]      mon_data [3];
    logic [19:0]     mon_full [3];
    logic            mon_busy [3];
    logic            mon_done [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        conv_window_reader_if #(.ACC_W(20)) bus ();

        conv_window_reader #(
            .OUT_SHIFT (g),
            .ACC_W     (20)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.start = start;

        // memory_module read ports: one-cycle registered read on enable 10
        always @(posedge clk) begin
            if (bus.en_INP == 2'b10) begin
                bus.out_A0 <= mem_a[bus.addr_A0];
                bus.out_A1 <= mem_a[bus.addr_A1];
                bus.out_A2 <= mem_a[bus.addr_A2];
            end
            if (bus.en_FIL == 2'b10) begin
                bus.out_F0 <= mem_f[bus.addr_F0];
                bus.out_F1 <= mem_f[bus.addr_F1];
                bus.out_F2 <= mem_f[bus.addr_F2];
            end
        end

        assign mon_a[g]      = {bus.addr_A2, bus.addr_A1, bus.addr_A0};
        assign mon_f[g]      = {bus.addr_F2, bus.addr_F1, bus.addr_F0};
        assign mon_en_inp[g] = bus.en_INP;
        assign mon_en_fil[g] = bus.en_FIL;
        assign mon_en_s[g]   = bus.en_S;
        assign mon_addr_s[g] = bus.addr_S0;
        assign mon_data[g]   = bus.data_w;
        assign mon_full[g]   = bus.result_full;
        assign mon_busy[g]   = bus.busy;
        assign mon_done[g]   = bus.done;
    end

    task automatic chk(input string name, input int inst, input longint act, input longint req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s [dut%0d]: got %0d, required %0d (cycle %0d)",
                     name, inst, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        rd_t re;
        wr_t we;
        int  dc;
        if (mon_on) begin
            if (mode == 1) begin
                for (int i = 0; i < 3; i++) begin
                    chk("idle_en_INP", i, mon_en_inp[i], 0);
                    chk("idle_en_FIL", i, mon_en_fil[i], 0);
                    chk("idle_en_S", i, mon_en_s[i], 0);
                    chk("idle_addr_A", i, mon_a[i], 0);
                    chk("idle_addr_F", i, mon_f[i], 0);
                    chk("idle_addr_S0", i, mon_addr_s[i], 0);
                    chk("idle_data_w", i, mon_data[i], 0);
                    chk("idle_result_full", i, mon_full[i], 0);
                    chk("idle_busy", i, mon_busy[i], 0);
                    chk("idle_done", i, mon_done[i], 0);
                end
            end
            if (mon_en_inp[0] != 2'b00 || mon_en_fil[0] != 2'b00) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_read", 0, 1, 0);
                end else begin
                    re = rd_q.pop_front();
                    for (int i = 0; i < 3; i++) begin
                        chk("read_en_INP", i, mon_en_inp[i], 2);
                        chk("read_en_FIL", i, mon_en_fil[i], 2);
                        for (int k = 0; k < 3; k++) begin
                            chk("read_addr_A", i, mon_a[i][k], re.a[k]);
                            chk("read_addr_F", i, mon_f[i][k], re.f[k]);
                        end
                    end
                end
            end
            if (mon_en_s[0] != 2'b00) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 0, 1, 0);
                end else begin
                    we = wr_q.pop_front();
                    for (int i = 0; i < 3; i++) begin
                        chk("write_en_S", i, mon_en_s[i], 3);
                        chk("write_addr_S0", i, mon_addr_s[i], we.addr);
                        chk("write_result_full", i, mon_full[i], we.full);
                        chk("write_data_w", i, mon_data[i], we.d[i]);
                    end
                end
            end
            if (mon_done[0]) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 0, 1, 0);
                end else begin
                    dc = done_q.pop_front();
                    chk("done_cycle", 0, cyc, dc);
                    for (int i = 0; i < 3; i++) begin
                        chk("done_all", i, mon_done[i], 1);
                        chk("busy_at_done", i, mon_busy[i], 0);
                    end
                end
            end
            if (final_chk && !final_seen) begin
                chk("reads_left", 0, rd_q.size(), 0);
                chk("writes_left", 0, wr_q.size(), 0);
                chk("dones_left", 0, done_q.size(), 0);
                final_seen = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expectations for one run, queued in the cycle start is raised.
    task automatic push_run(input bit all_max);
        for (int idx = 0; idx < 4; idx++) begin
            for (int r = 0; r < 3; r++) begin
                rd_t e;
                for (int k = 0; k < 3; k++) begin
                    e.a[k] = 4'(((idx / 2) + r) * 4 + (idx % 2) + k);
                    e.f[k] = 4'(r * 3 + k);
                end
                rd_q.push_back(e);
            end
        end
        for (int idx = 0; idx < 4; idx++) begin
            wr_t w;
            w.addr = 2'(idx);
            w.full = all_max ? 20'd585225 : 20'(exp_full[idx]);
            w.d[0] = 8'd255;
            w.d[1] = all_max ? 8'd255 : 8'(exp_d1[idx]);
            w.d[2] = all_max ? 8'd255 : 8'(exp_d2[idx]);
            wr_q.push_back(w);
        end
        done_q.push_back(cyc + 21);
    endtask

    // Returns in the done cycle (21st after the start edge).
    task automatic run(input bit all_max, input bit repulse, input int hold_cycles);
        push_run(all_max);
        start = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            step();
            start = (hold_cycles > 0) || (repulse && (i == 5 || i == 12));
        end
        if (hold_cycles > 0) begin
            repeat (hold_cycles) step();
            start = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'(i);
            mem_f[i] = (i < 9) ? 8'(i + 1) : 8'd0;
        end

        // reset values, during and just after reset
        repeat (3) step();
        mon_on = 1'b1;
        mode   = 1;
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();
        mode = 0;

        // basic run: all three shift settings at once
        run(1'b0, 1'b0, 0);
        repeat (4) step();

        // reset during output 1, ph2 (cycle 8)
        push_run(1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        mode = 1;
        repeat (30) step();
        mode = 0;
        run(1'b0, 1'b0, 0);
        repeat (4) step();

        // start re-pulsed while busy, then a start in the cycle after done
        run(1'b0, 1'b1, 0);
        step();
        run(1'b0, 1'b0, 0);
        repeat (4) step();

        // start held high across and well past a run
        run(1'b0, 1'b0, 40);
        repeat (4) step();

        // all-255 operands
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'd255;
            mem_f[i] = 8'd255;
        end
        run(1'b1, 1'b0, 0);
        repeat (4) step();

        final_chk = 1'b1;
        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/conv_window_reader.md
Name: conv_window_reader

Overview:
- Read-side sequencer for memory_module.
- After the loader has written the 4x4 input matrix and the 3x3 filter, this block performs the 3x3 valid convolution:
  - walks the three read ports of each bank, one filter row per cycle;
  - accumulates nine products per output;
  - writes the four 8-bit results (2x2) into the serial-mode output memory.
- Sits between memory_module and the top-level controller, which only pulses start and waits for done.

Parameters:
- OUT_SHIFT, 0, right shift applied to the 20-bit accumulator before saturation to 8 bits.
- ACC_W, 20, accumulator width. Must be at least 20, since 9*255*255 = 585225.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to run one full convolution
- addr_A0, addr_A1, addr_A2  out  4 each  input-matrix read addresses, row-major (row*4+col)
- addr_F0, addr_F1, addr_F2  out  4 each  filter read addresses, row-major (row*3+col)
- en_INP, en_FIL  out  2 each  bank enables: 00 idle, 10 read, 11 write (never driven 11 by this block)
- out_A0, out_A1, out_A2  in  8 each  input-matrix read data
- out_F0, out_F1, out_F2  in  8 each  filter read data
- data_w  out  8  result write data to memory_module
- addr_S0  out  2  serial-mode output address, 0..3 = output index orow*2+ocol
- en_S  out  2  serial output memory enable: 00 idle, 11 write
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the fourth result is written
- result_full  out  ACC_W  unsaturated accumulator of the most recently written result

Behaviour:
- Reset values: all addresses 0; en_INP, en_FIL and en_S = 00; data_w 0; busy 0; done 0; result_full 0; FSM in IDLE.
- Memory timing is fixed: read data is valid on out_* one cycle after an address is presented with enable 10.
- FSM states: IDLE, RUN, WRITE, DONE.
  - IDLE -> RUN when start=1. start is ignored in every other state.
  - RUN -> WRITE after phase 3.
  - WRITE -> RUN with the next output index while idx < 3; WRITE -> DONE when idx = 3.
  - DONE -> IDLE unconditionally.
- Per output (orow, ocol), RUN runs a 2-bit phase counter ph = 0..3:
  - ph0: issue filter row r=0.
  - ph1: issue row 1; acc <= sum of the three row-0 products.
  - ph2: issue row 2; acc += row-1 products.
  - ph3: enables 00; acc += row-2 products.
- Issuing filter row r means:
  - en_INP = en_FIL = 10;
  - addr_Ak = (orow+r)*4 + ocol + k;
  - addr_Fk = r*3 + k, for k = 0..2.
- WRITE cycle:
  - en_S = 11, addr_S0 = idx;
  - data_w = min(acc >> OUT_SHIFT, 255);
  - result_full = acc.
- Cycle budget:
  - 5 cycles per output, 20 cycles total.
  - done is high in the 21st cycle after the start edge.
  - busy drops in that same cycle.
- Output order: idx 0 (0,0), 1 (0,1), 2 (1,0), 3 (1,1).
- Arithmetic: all operands unsigned. Each 8x8 product is 16 bits; the three-term row sum is 18 bits; the accumulator is ACC_W bits and never wraps.
- Enables outside read and write cycles are 00. en_S is 11 only in WRITE.
- Reset mid-operation: on the reset edge, enables go to 00 and the FSM to IDLE. No partial result is written and done is not pulsed.
- start held high continuously: only one run is started. A new run begins only if start is high while in IDLE.

Decomposition:
- Shared package conv_pkg holds:
  - enable encodings EN_IDLE=2'b00, EN_READ=2'b10, EN_WRITE=2'b11;
  - dimensions IN_DIM=4, FIL_DIM=3, OUT_DIM=2;
  - state enum {IDLE, RUN, WRITE, DONE}.
- One sub-module, conv_mac3: three 8x8 unsigned multipliers plus a 3-input adder producing the 18-bit row sum. Purely combinational.

Test Plan:
- Basic run: load A[i]=i for i=0..15 and F[i]=i+1 for i=0..8; OUT_SHIFT=0; pulse start.
  - Required result_full sequence: 303, 348, 483, 528.
  - data_w = 255 (saturated) at addr_S0 0..3.
  - done at cycle 21.
- Same data with OUT_SHIFT=2: data_w = 75, 87, 120, 132. With OUT_SHIFT=1: 151, 174, 241, 255.
- Address trace for output 3 (1,1):
  - rows issued as A {5,6,7}/F {0,1,2}, then A {9,10,11}/F {3,4,5}, then A {13,14,15}/F {6,7,8};
  - en_INP = en_FIL = 10 on exactly those 3 cycles.
- Mid-run reset: assert rst during output 1, ph2.
  - Next cycle: all enables 00, busy 0.
  - en_S is never 11 afterwards, and done never pulses.
  - A fresh start then reproduces the basic-run results.
- start re-pulsed while busy is ignored: exactly 4 writes and a single done. A start in the cycle after done launches a second identical run.
- All-255 operands, OUT_SHIFT=0: result_full = 585225 with no overflow; data_w = 255.
